// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the Z80 interrupt controller: sequencer states,
// interrupt modes and default restart vectors.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INT_ACK = 2'd1,
        INT_VEC = 2'd2
    } int_state_t;

    typedef enum logic [1:0] {
        IM0 = 2'd0,
        IM1 = 2'd1,
        IM2 = 2'd2
    } im_t;

    localparam logic [15:0] DEFAULT_NMI_VECTOR = 16'h0066;
    localparam logic [15:0] DEFAULT_IM1_VECTOR = 16'h0038;

endpackage

// File: rtl/interrupt_controller_nmi_edge_latch.sv
// NMI rising-edge detector and pending latch; a new edge in the clearing
// cycle keeps the latch set so no NMI is lost.
module nmi_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic nmi,
    input  logic clear,
    output logic pending
);

    logic nmi_q;
    logic rise;

    assign rise = nmi && !nmi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            nmi_q <= nmi;
            if (rise)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Z80 INT/NMI acceptance at instruction boundaries, INTA handshake and
// restart vector generation for IM 0/1/2.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR = DEFAULT_NMI_VECTOR,
    parameter logic [15:0] IM1_VECTOR = DEFAULT_IM1_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nmi,
    input  logic        irq,
    input  logic        iff1,
    input  logic        delayed_enable_interrupts,
    input  logic [7:0]  reg_i,
    input  logic        next_insn_done,
    input  logic        halted,
    input  logic        im_wr,
    input  logic [1:0]  im_in,
    input  logic        inta_done,
    input  logic [7:0]  inta_data,
    output logic        inta_req,
    output logic        accept_nmi,
    output logic        disable_interrupts,
    output logic        vector_valid,
    output logic        vector_indirect,
    output logic [15:0] vector_addr,
    output logic [1:0]  reg_im,
    output logic        nmi_pending,
    output logic [1:0]  state_dbg
);

    // Handshake: inta_req stays high from the accepting edge until the
    // cycle in which the bus sequencer reports inta_done; the byte on
    // inta_data is captured in that cycle.

    int_state_t state, next_state;
    logic [7:0] vec_data;
    logic       boundary;
    logic       take_nmi;
    logic       take_int;
    logic       in_vec;

    assign boundary = next_insn_done || halted;
    assign take_nmi = !reset && (state == IDLE) && boundary && nmi_pending;
    assign take_int = !reset && (state == IDLE) && boundary && !nmi_pending
                      && irq && iff1 && !delayed_enable_interrupts;
    assign in_vec   = !reset && (state == INT_VEC);

    nmi_edge_latch u_nmi_latch (
        .clk     (clk),
        .reset   (reset),
        .nmi     (nmi),
        .clear   (take_nmi),
        .pending (nmi_pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            reg_im   <= IM0;
            vec_data <= 8'h00;
        end else begin
            state <= next_state;
            if (im_wr)
                reg_im <= (im_in == 2'd3) ? IM0 : im_in;
            if (state == INT_ACK && inta_done)
                vec_data <= inta_data;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take_int) next_state = INT_ACK;
            INT_ACK: if (inta_done) next_state = INT_VEC;
            INT_VEC: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        vector_addr     = 16'h0000;
        vector_indirect = 1'b0;
        if (take_nmi) begin
            vector_addr = NMI_VECTOR;
        end else if (in_vec) begin
            case (reg_im)
                IM1: vector_addr = IM1_VECTOR;
                IM2: begin
                    vector_addr     = {reg_i, vec_data & 8'hFE};
                    vector_indirect = 1'b1;
                end
                // IM 0 only honours RST opcodes on the data bus
                default: vector_addr = {8'h00, vec_data & 8'h38};
            endcase
        end
    end

    assign inta_req           = (state == INT_ACK);
    assign accept_nmi         = take_nmi;
    assign disable_interrupts = take_int;
    assign vector_valid       = take_nmi || in_vec;
    assign state_dbg          = state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: NMI latch/accept, INT handshake
// in IM 0/1/2, EI shadow, NMI-over-INT priority and reset abort.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        nmi, irq, iff1, delayed_enable_interrupts;
    logic [7:0]  reg_i;
    logic        next_insn_done, halted, im_wr;
    logic [1:0]  im_in;
    logic        inta_done;
    logic [7:0]  inta_data;
    logic        inta_req, accept_nmi, disable_interrupts;
    logic        vector_valid, vector_indirect;
    logic [15:0] vector_addr;
    logic [1:0]  reg_im;
    logic        nmi_pending;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_ACK = 2'd1, S_VEC = 2'd2;

    interrupt_controller dut (
        .clk                       (clk),
        .reset                     (reset),
        .nmi                       (nmi),
        .irq                       (irq),
        .iff1                      (iff1),
        .delayed_enable_interrupts (delayed_enable_interrupts),
        .reg_i                     (reg_i),
        .next_insn_done            (next_insn_done),
        .halted                    (halted),
        .im_wr                     (im_wr),
        .im_in                     (im_in),
        .inta_done                 (inta_done),
        .inta_data                 (inta_data),
        .inta_req                  (inta_req),
        .accept_nmi                (accept_nmi),
        .disable_interrupts        (disable_interrupts),
        .vector_valid              (vector_valid),
        .vector_indirect           (vector_indirect),
        .vector_addr               (vector_addr),
        .reg_im                    (reg_im),
        .nmi_pending               (nmi_pending),
        .state_dbg                 (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; nmi = 0; irq = 0; iff1 = 0; delayed_enable_interrupts = 0;
        reg_i = 8'h00; next_insn_done = 0; halted = 0; im_wr = 0; im_in = 2'd0;
        inta_done = 0; inta_data = 8'h00;
        step(); step();
        reset = 1'b0;

        // reset state
        chk("rst_inta_req", 16'(inta_req), 16'd0);
        chk("rst_accept_nmi", 16'(accept_nmi), 16'd0);
        chk("rst_disable", 16'(disable_interrupts), 16'd0);
        chk("rst_vector_valid", 16'(vector_valid), 16'd0);
        chk("rst_vector_addr", vector_addr, 16'h0000);
        chk("rst_reg_im", 16'(reg_im), 16'd0);
        chk("rst_nmi_pending", 16'(nmi_pending), 16'd0);
        chk("rst_state", 16'(state_dbg), 16'(S_IDLE));

        // NMI edge mid-instruction, serviced at the boundary
        nmi = 1'b1;
        step();
        chk("nmi_pend_set", 16'(nmi_pending), 16'd1);
        chk("nmi_no_accept_mid", 16'(accept_nmi), 16'd0);
        step();
        chk("nmi_pend_hold", 16'(nmi_pending), 16'd1);
        next_insn_done = 1'b1;
        #1;
        chk("nmi_accept", 16'(accept_nmi), 16'd1);
        chk("nmi_vvalid", 16'(vector_valid), 16'd1);
        chk("nmi_vaddr", vector_addr, 16'h0066);
        chk("nmi_vind", 16'(vector_indirect), 16'd0);
        step();
        next_insn_done = 1'b0;
        #1;
        chk("nmi_pend_clr", 16'(nmi_pending), 16'd0);
        chk("nmi_accept_off", 16'(accept_nmi), 16'd0);
        nmi = 1'b0;

        // IM 1 INT
        im_wr = 1'b1; im_in = 2'd1;
        step();
        im_wr = 1'b0;
        chk("im1_reg_im", 16'(reg_im), 16'd1);
        iff1 = 1'b1; irq = 1'b1; next_insn_done = 1'b1;
        #1;
        chk("im1_disable", 16'(disable_interrupts), 16'd1);
        chk("im1_no_nmi", 16'(accept_nmi), 16'd0);
        chk("im1_req_before", 16'(inta_req), 16'd0);
        step();
        next_insn_done = 1'b0; irq = 1'b0;
        #1;
        chk("im1_state_ack", 16'(state_dbg), 16'(S_ACK));
        chk("im1_req", 16'(inta_req), 16'd1);
        chk("im1_disable_once", 16'(disable_interrupts), 16'd0);
        step();
        chk("im1_req_hold", 16'(inta_req), 16'd1);
        chk("im1_no_vvalid_ack", 16'(vector_valid), 16'd0);
        inta_done = 1'b1; inta_data = 8'hAA;
        step();
        inta_done = 1'b0;
        #1;
        chk("im1_vvalid", 16'(vector_valid), 16'd1);
        chk("im1_vaddr", vector_addr, 16'h0038);
        chk("im1_vind", 16'(vector_indirect), 16'd0);
        chk("im1_req_drop", 16'(inta_req), 16'd0);
        step();
        chk("im1_vvalid_off", 16'(vector_valid), 16'd0);
        chk("im1_back_idle", 16'(state_dbg), 16'(S_IDLE));

        // IM 2 INT
        im_wr = 1'b1; im_in = 2'd2; reg_i = 8'h12;
        step();
        im_wr = 1'b0;
        irq = 1'b1; next_insn_done = 1'b1;
        step();
        irq = 1'b0; next_insn_done = 1'b0;
        inta_done = 1'b1; inta_data = 8'h35;
        step();
        inta_done = 1'b0;
        #1;
        chk("im2_vvalid", 16'(vector_valid), 16'd1);
        chk("im2_vaddr", vector_addr, 16'h1234);
        chk("im2_vind", 16'(vector_indirect), 16'd1);
        step();

        // EI shadow blocks INT at the first boundary only
        irq = 1'b1; delayed_enable_interrupts = 1'b1; next_insn_done = 1'b1;
        #1;
        chk("ei_blocked", 16'(disable_interrupts), 16'd0);
        step();
        chk("ei_stay_idle", 16'(state_dbg), 16'(S_IDLE));
        delayed_enable_interrupts = 1'b0;
        #1;
        chk("ei_accepted", 16'(disable_interrupts), 16'd1);
        step();
        irq = 1'b0; next_insn_done = 1'b0; inta_done = 1'b1; inta_data = 8'h00;
        step();
        inta_done = 1'b0;
        step();

        // IM 3 maps to IM 0; NMI wins over a simultaneous INT
        im_wr = 1'b1; im_in = 2'd3;
        step();
        im_wr = 1'b0;
        chk("im3_as_im0", 16'(reg_im), 16'd0);
        nmi = 1'b1; irq = 1'b1;
        step();
        next_insn_done = 1'b1;
        #1;
        chk("prio_nmi_accept", 16'(accept_nmi), 16'd1);
        chk("prio_no_int", 16'(disable_interrupts), 16'd0);
        step();
        chk("prio_int_next", 16'(disable_interrupts), 16'd1);
        chk("prio_no_nmi2", 16'(accept_nmi), 16'd0);
        step();
        irq = 1'b0; next_insn_done = 1'b0; inta_done = 1'b1; inta_data = 8'hFF;
        step();
        inta_done = 1'b0;
        #1;
        chk("im0_vaddr", vector_addr, 16'h0038);
        chk("im0_vind", 16'(vector_indirect), 16'd0);
        step();

        // new NMI edge in the accepting cycle keeps the latch set
        nmi = 1'b0;
        step();
        nmi = 1'b1;
        step();
        nmi = 1'b0;
        step();
        nmi = 1'b1; next_insn_done = 1'b1;
        #1;
        chk("setwin_accept", 16'(accept_nmi), 16'd1);
        step();
        chk("setwin_pending", 16'(nmi_pending), 16'd1);
        chk("setwin_accept2", 16'(accept_nmi), 16'd1);
        step();
        next_insn_done = 1'b0;
        #1;
        chk("setwin_cleared", 16'(nmi_pending), 16'd0);
        nmi = 1'b0;

        // NMI during INT_ACK is held; reset aborts the handshake
        im_wr = 1'b1; im_in = 2'd1;
        step();
        im_wr = 1'b0;
        irq = 1'b1; next_insn_done = 1'b1;
        step();
        irq = 1'b0; next_insn_done = 1'b0; nmi = 1'b1; halted = 1'b1;
        step();
        chk("ack_nmi_latched", 16'(nmi_pending), 16'd1);
        chk("ack_no_accept", 16'(accept_nmi), 16'd0);
        chk("ack_no_vvalid", 16'(vector_valid), 16'd0);
        chk("ack_req", 16'(inta_req), 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_req", 16'(inta_req), 16'd0);
        chk("abort_vvalid", 16'(vector_valid), 16'd0);
        chk("abort_reg_im", 16'(reg_im), 16'd0);
        chk("abort_state", 16'(state_dbg), 16'(S_IDLE));
        chk("abort_pending", 16'(nmi_pending), 16'd0);
        halted = 1'b0; nmi = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Sequences Z80 maskable (INT) and non-maskable (NMI) interrupt acceptance at instruction boundaries. Reads the interrupt flip-flops and I register from the IR register block, and drives that block's accept_nmi / disable_interrupts strobes. Runs the INT acknowledge handshake with the bus sequencer. Produces the restart vector for the CPU core according to interrupt mode (IM 0/1/2).

Parameters:
NMI_VECTOR, 16'h0066, NMI restart address
IM1_VECTOR, 16'h0038, IM 1 restart address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
nmi  in  1  NMI request, active-high; rising edge latched
irq  in  1  INT request, active-high level
iff1  in  1  IFF1 from IR register block
delayed_enable_interrupts  in  1  EI shadow from IR register block; blocks INT
reg_i  in  8  I register
next_insn_done  in  1  instruction completes on next posedge (boundary)
halted  in  1  CPU in HALT; every cycle is a boundary
im_wr  in  1  IM instruction executing
im_in  in  2  new mode (0,1,2; 3 treated as 0)
inta_done  in  1  bus sequencer finished INTA cycle
inta_data  in  8  byte read during INTA
inta_req  out  1  request INTA bus cycle
accept_nmi  out  1  one-cycle strobe to IR register block
disable_interrupts  out  1  one-cycle strobe clearing IFF1/IFF2 on INT accept
vector_valid  out  1  one-cycle strobe: vector_addr valid, core must push PC and jump
vector_indirect  out  1  with vector_valid: vector_addr is IM 2 table pointer, core fetches word
vector_addr  out  16  restart address or IM 2 table pointer
reg_im  out  2  current interrupt mode
nmi_pending  out  1  NMI latched, not yet serviced

Behaviour:
- Reset: all outputs 0, reg_im=0, state IDLE, NMI latch and edge register cleared. Reset mid-handshake aborts to IDLE; no strobes.
- NMI edge: nmi_q registers nmi. Rising edge (nmi && !nmi_q) sets nmi_pending. Latch clears only when NMI is accepted. Edges while pending are absorbed (no count).
- boundary = next_insn_done || halted.
- im_wr: reg_im <= (im_in==3) ? 0 : im_in on the posedge. Effective for any INT accepted from the following cycle on.
- States: IDLE, INT_ACK, INT_VEC.
- IDLE, boundary, priority 1, nmi_pending:
  - one-cycle accept_nmi=1, vector_valid=1, vector_addr=NMI_VECTOR, vector_indirect=0.
  - clear nmi_pending; stay IDLE.
  - A new NMI edge in the same cycle re-sets the latch (set wins over clear).
- IDLE, boundary, priority 2, irq && iff1 && !delayed_enable_interrupts:
  - one-cycle disable_interrupts=1.
  - go INT_ACK with inta_req=1 registered on the same edge.
- INT_ACK: hold inta_req=1 until inta_done. On inta_done, capture inta_data, drop inta_req, go INT_VEC.
- INT_VEC (one cycle): vector_valid=1, then IDLE. vector_addr by mode:
  - IM 0: {8'h00, inta_data & 8'h38} (RST decode only).
  - IM 1: IM1_VECTOR.
  - IM 2: {reg_i, inta_data & 8'hFE}, vector_indirect=1.
- irq sampled only at boundary in IDLE. irq deasserting during INT_ACK does not abort.
- NMI arriving during INT_ACK/INT_VEC is latched and serviced at the next boundary after return to IDLE.
- No strobe is ever asserted outside IDLE-at-boundary or INT_VEC. accept_nmi and disable_interrupts are never asserted together.

Decomposition:
- Shared z80 package: int_state_t enum (IDLE, INT_ACK, INT_VEC), im_t enum, default vector constants.
- One sub-module: nmi_edge_latch (edge detect, pending set/clear with set priority).

Test Plan:
- Reset, then nmi 0->1 mid-instruction, next_insn_done -> nmi_pending=1 until boundary; that cycle accept_nmi=1, vector_addr=16'h0066; then nmi_pending=0.
- iff1=1, IM 1, irq=1 at boundary -> disable_interrupts one cycle; inta_req until inta_done; then vector_valid, vector_addr=16'h0038.
- IM 2, reg_i=8'h12, inta_data=8'h35 -> vector_addr=16'h1234, vector_indirect=1.
- irq=1, iff1=1, delayed_enable_interrupts=1 at boundary -> no acceptance. Next boundary with shadow 0 -> accepted.
- irq and NMI edge together at boundary -> NMI serviced first, INT at following boundary. IM 0, inta_data=8'hFF -> vector_addr=16'h0038.
- reset asserted in INT_ACK -> inta_req=0 next cycle, no vector_valid, reg_im=0.
